// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
package mem_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StBytes,
        StWrite,
        StVrd,
        StVcmp,
        StDone,
        StError
    } state_e;

    // Error codes reported on ERR_CODE
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrLen     = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrCsum    = 2'd3;

    localparam int unsigned ByteW = 8;

    // States in which a load is in progress
    function automatic logic is_busy(input state_e s);
        return s inside {StLen, StBytes, StWrite, StVrd, StVcmp};
    endfunction

    // States in which Memory is selected
    function automatic logic drives_mem(input state_e s);
        return s inside {StWrite, StVrd, StVcmp};
    endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words.
module mem_loader_word_assembler
    import mem_loader_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             byte_valid_i,
    input  logic [ByteW-1:0] byte_i,
    output logic [31:0]      word_o,
    output logic             word_valid_o
);

    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] word_q, word_d;

    // Next byte lane and word contents
    always_comb begin
        bidx_d = bidx_q;
        word_d = word_q;
        if (clear_i) begin
            bidx_d = '0;
        end else if (byte_valid_i) begin
            word_d[{bidx_q, 3'b000} +: ByteW] = byte_i;
            bidx_d = bidx_q + 2'd1;
        end
    end

    // Byte lane index and shift register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bidx_q <= '0;
            word_q <= '0;
        end else begin
            bidx_q <= bidx_d;
            word_q <= word_d;
        end
    end

    // Pulses with the 4th byte; the full word is visible in word_o the next cycle
    assign word_valid_o = byte_valid_i && !clear_i && (bidx_q == 2'd3);
    assign word_o       = word_q;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: receives a counted word stream, writes it to Memory, verifies by
// XOR checksum and only then releases the CPU from reset.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned AW      = 7,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        RX_VALID,
    input  logic [7:0]  RX_DATA,
    output logic        CS,
    output logic        WE,
    output logic [31:0] ADDR,
    inout  wire  [31:0] Mem_Bus,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    state_e         state_q, state_d;
    logic [CW-1:0]  n_q, n_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    logic [CW-1:0]  vcnt_q, vcnt_d;
    logic [31:0]    wsum_q, wsum_d;
    logic [31:0]    vsum_q, vsum_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           cs_q, we_q, busy_q, done_q, err_q, cpu_rst_q;

    logic           last_w, accept, clear, word_valid, timeout_hit, len_ok;
    logic [31:0]    word;

    assign last_w = (wcnt_q + CntOne) == n_q;
    // A byte during the final WRITE has no word left to belong to
    assign accept = RX_VALID && ((state_q == StBytes) || (state_q == StWrite && !last_w));
    assign clear  = state_q inside {StIdle, StLen, StDone, StError};

    mem_loader_word_assembler u_asm (
        .clk_i        (CLK),
        .rst_i        (RST),
        .clear_i      (clear),
        .byte_valid_i (accept),
        .byte_i       (RX_DATA),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    assign timeout_hit = (idle_q == TW'(TIMEOUT - 1)) && !RX_VALID;
    assign len_ok      = (RX_DATA == 8'd0) || ({24'd0, RX_DATA} <= DEPTH);

    // Next-state, counter and checksum logic
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wcnt_d     = wcnt_q;
        vcnt_d     = vcnt_q;
        wsum_d     = wsum_q;
        vsum_d     = vsum_q;
        err_code_d = err_code_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (START) begin
                    state_d    = StLen;
                    n_d        = '0;
                    wcnt_d     = '0;
                    vcnt_d     = '0;
                    wsum_d     = '0;
                    vsum_d     = '0;
                    err_code_d = ErrNone;
                end
            end
            StLen: begin
                if (RX_VALID) begin
                    if (!len_ok) begin
                        state_d    = StError;
                        err_code_d = ErrLen;
                    end else begin
                        state_d = StBytes;
                        n_d     = (RX_DATA == 8'd0) ? DepthCnt : CW'(RX_DATA);
                        wcnt_d  = '0;
                    end
                end else if (timeout_hit) begin
                    state_d    = StError;
                    err_code_d = ErrTimeout;
                end
            end
            StBytes: begin
                if (word_valid) begin
                    state_d = StWrite;
                end else if (timeout_hit) begin
                    state_d    = StError;
                    err_code_d = ErrTimeout;
                end
            end
            StWrite: begin
                wsum_d = wsum_q ^ word;
                wcnt_d = wcnt_q + CntOne;
                if (last_w) begin
                    state_d = StVrd;
                    vcnt_d  = '0;
                end else begin
                    state_d = StBytes;
                end
            end
            StVrd: begin
                state_d = StVcmp;
            end
            StVcmp: begin
                vsum_d = vsum_q ^ Mem_Bus;
                vcnt_d = vcnt_q + CntOne;
                if (vcnt_d == n_q) begin
                    if (vsum_d == wsum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StError;
                        err_code_d = ErrCsum;
                    end
                end else begin
                    state_d = StVrd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Idle counter: restarts on any byte or state change, runs only while waiting for bytes
    always_comb begin
        idle_d = idle_q + TW'(1);
        if (state_d != state_q || RX_VALID || !(state_q inside {StLen, StBytes})) begin
            idle_d = '0;
        end
    end

    // Memory address for the upcoming cycle
    always_comb begin
        addr_d = '0;
        if (state_d == StWrite) begin
            addr_d = wcnt_d[AW-1:0];
        end else if (state_d inside {StVrd, StVcmp}) begin
            addr_d = vcnt_d[AW-1:0];
        end
    end

    // FSM state, datapath and registered outputs decoded from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            n_q        <= '0;
            wcnt_q     <= '0;
            vcnt_q     <= '0;
            wsum_q     <= '0;
            vsum_q     <= '0;
            idle_q     <= '0;
            err_code_q <= ErrNone;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wcnt_q     <= wcnt_d;
            vcnt_q     <= vcnt_d;
            wsum_q     <= wsum_d;
            vsum_q     <= vsum_d;
            idle_q     <= idle_d;
            err_code_q <= err_code_d;
            addr_q     <= addr_d;
            cs_q       <= drives_mem(state_d);
            we_q       <= (state_d == StWrite);
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == StDone);
            err_q      <= (state_d == StError);
            cpu_rst_q  <= (state_d != StDone);
        end
    end

    // Loader owns the bus only while writing; Memory drives it on reads
    assign Mem_Bus  = (cs_q && we_q) ? word : 32'bz;
    assign ADDR     = {{(32 - AW){1'b0}}, addr_q};
    assign CS       = cs_q;
    assign WE       = we_q;
    assign CPU_RST  = cpu_rst_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: 128-word negedge Memory model, table-driven loads and
// hand-written timeout and reset sequences.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int unsigned TOUT = 64;

    logic        CLK = 1'b0;
    logic        RST, START, RX_VALID;
    logic [7:0]  RX_DATA;
    logic        CS, WE, CPU_RST, BUSY, DONE, ERR;
    logic [31:0] ADDR;
    logic [1:0]  ERR_CODE;
    wire  [31:0] Mem_Bus;

    // An undriven bus reads as all ones
    pullup (Mem_Bus);

    mem_loader #(.DEPTH(128), .AW(7), .TIMEOUT(TOUT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .RX_VALID (RX_VALID),
        .RX_DATA  (RX_DATA),
        .CS       (CS),
        .WE       (WE),
        .ADDR     (ADDR),
        .Mem_Bus  (Mem_Bus),
        .CPU_RST  (CPU_RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    // Memory model: acts on negedge, drives the bus on selected reads
    logic [31:0] ram [0:127];
    logic [31:0] mem_dout = 32'd0;
    logic        corrupt_en;
    always @(negedge CLK) begin
        if (CS) begin
            if (WE) ram[ADDR[6:0]] <= Mem_Bus;
            mem_dout <= ram[ADDR[6:0]];
        end
    end
    assign Mem_Bus = (CS && !WE) ? ((corrupt_en && ADDR[6:0] == 7'd1) ? 32'd0 : mem_dout)
                                 : 32'bz;

    // Bus activity monitor, sampled mid-cycle
    int unsigned wr_cnt = 0, rd_cnt = 0, cs_cnt = 0, we_cnt = 0, bad_addr = 0, bus_bad = 0;
    logic [31:0] last_waddr = 32'd0;
    always @(negedge CLK) begin
        if (CS && WE) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= ADDR;
        end
        if (CS && !WE) rd_cnt <= rd_cnt + 1;
        if (CS) cs_cnt <= cs_cnt + 1;
        if (WE) we_cnt <= we_cnt + 1;
        if (CS && ADDR > 32'd127) bad_addr <= bad_addr + 1;
        if (!CS && Mem_Bus !== 32'hFFFF_FFFF) bus_bad <= bus_bad + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        @(posedge CLK); #1;
        RX_VALID = 1'b0;
        repeat (gap) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_end(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (DONE || ERR) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        chk("end_reached", 32'(ok), 32'd1);
    endtask

    function automatic logic [31:0] gen_word(input int v, input int i);
        return (32'h9E37_79B9 * 32'(i + 1)) + (32'(v) * 32'h0101_0101);
    endfunction

    typedef struct {
        logic [7:0] cnt;      // count byte
        int         nbytes;   // data bytes sent
        int         gap;      // idle cycles after each byte
        bit         corrupt;  // Memory returns 0 when reading word 1
        logic [1:0] code;     // expected ERR_CODE
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_w [128];
    logic [7:0]  t1 [13];

    initial begin
        int unsigned wr0, rd0, cs0, we0, ba0, bb0;
        int          exp_wr, bad_words;
        logic [31:0] w;

        vecs[0] = '{cnt: 8'h01, nbytes: 4,   gap: 1, corrupt: 1'b0, code: ErrNone};
        vecs[1] = '{cnt: 8'hC8, nbytes: 0,   gap: 0, corrupt: 1'b0, code: ErrLen};
        vecs[2] = '{cnt: 8'h03, nbytes: 12,  gap: 2, corrupt: 1'b0, code: ErrNone};
        vecs[3] = '{cnt: 8'h81, nbytes: 0,   gap: 0, corrupt: 1'b0, code: ErrLen};
        vecs[4] = '{cnt: 8'h00, nbytes: 512, gap: 0, corrupt: 1'b0, code: ErrNone};
        vecs[5] = '{cnt: 8'h02, nbytes: 8,   gap: 0, corrupt: 1'b1, code: ErrCsum};
        vecs[6] = '{cnt: 8'h80, nbytes: 512, gap: 1, corrupt: 1'b0, code: ErrNone};
        vecs[7] = '{cnt: 8'h02, nbytes: 8,   gap: 0, corrupt: 1'b0, code: ErrNone};
        t1 = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h01, 8'h00, 8'h00, 8'h00};

        RST = 1'b0; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'd0; corrupt_en = 1'b0;
        #2 RST = 1'b1;
        #2;
        chk("rst_cs",       32'(CS),       32'd0);
        chk("rst_we",       32'(WE),       32'd0);
        chk("rst_addr",     ADDR,          32'd0);
        chk("rst_bus_free", Mem_Bus,       32'hFFFF_FFFF);
        chk("rst_cpu_rst",  32'(CPU_RST),  32'd1);
        chk("rst_busy",     32'(BUSY),     32'd0);
        chk("rst_done",     32'(DONE),     32'd0);
        chk("rst_err",      32'(ERR),      32'd0);
        chk("rst_code",     32'(ERR_CODE), 32'd0);
        #3 RST = 1'b0;
        @(posedge CLK); #1;

        // Exact byte stream, back-to-back, plus one stray byte during the last WRITE
        rd0 = rd_cnt;
        pulse_start();
        foreach (t1[i]) send_byte(t1[i], 0);
        send_byte(8'hFF, 0);
        wait_end(100);
        chk("t1_ram0",    ram[0],         32'h1234_5678);
        chk("t1_ram1",    ram[1],         32'hDEAD_BEEF);
        chk("t1_ram2",    ram[2],         32'h0000_0001);
        chk("t1_reads",   rd_cnt - rd0,   32'd6);
        chk("t1_done",    32'(DONE),      32'd1);
        chk("t1_cpu_rst", 32'(CPU_RST),   32'd0);
        chk("t1_code",    32'(ERR_CODE),  32'd0);

        for (int v = 0; v < 8; v++) begin
            corrupt_en = vecs[v].corrupt;
            exp_wr = (vecs[v].code == ErrNone || vecs[v].code == ErrCsum) ? vecs[v].nbytes / 4 : 0;
            wr0 = wr_cnt; rd0 = rd_cnt; cs0 = cs_cnt; ba0 = bad_addr; bb0 = bus_bad;
            pulse_start();
            chk("start_busy", 32'(BUSY),     32'd1);
            chk("start_code", 32'(ERR_CODE), 32'd0);
            chk("start_done", 32'(DONE),     32'd0);
            send_byte(vecs[v].cnt, vecs[v].gap);
            for (int b = 0; b < vecs[v].nbytes; b++) begin
                w = gen_word(v, b / 4);
                exp_w[b / 4] = w;
                send_byte(w[8 * (b % 4) +: 8], vecs[v].gap);
            end
            wait_end(700);
            chk("vec_done",    32'(DONE),         32'(vecs[v].code == ErrNone));
            chk("vec_err",     32'(ERR),          32'(vecs[v].code != ErrNone));
            chk("vec_code",    32'(ERR_CODE),     32'(vecs[v].code));
            chk("vec_cpu_rst", 32'(CPU_RST),      32'(vecs[v].code != ErrNone));
            chk("vec_busy",    32'(BUSY),         32'd0);
            chk("vec_writes",  wr_cnt - wr0,      32'(exp_wr));
            chk("vec_reads",   rd_cnt - rd0,      32'(2 * exp_wr));
            chk("vec_cs",      cs_cnt - cs0,      32'(3 * exp_wr));
            chk("vec_badaddr", bad_addr - ba0,    32'd0);
            chk("vec_busfree", bus_bad - bb0,     32'd0);
            if (exp_wr > 0) chk("vec_last_addr", last_waddr, 32'(exp_wr - 1));
            if (vecs[v].code == ErrNone) begin
                bad_words = 0;
                for (int i = 0; i < exp_wr; i++) if (ram[i] !== exp_w[i]) bad_words++;
                chk("vec_ram", 32'(bad_words), 32'd0);
            end
        end
        corrupt_en = 1'b0;

        // Two bytes then silence: must time out near TOUT idle cycles, never writing
        we0 = we_cnt;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        repeat (TOUT - 4) begin
            @(posedge CLK); #1;
        end
        chk("to_early_err",  32'(ERR),  32'd0);
        chk("to_early_busy", 32'(BUSY), 32'd1);
        wait_end(20);
        chk("to_err",    32'(ERR),      32'd1);
        chk("to_code",   32'(ERR_CODE), 32'(ErrTimeout));
        chk("to_no_we",  we_cnt - we0,  32'd0);
        chk("to_cpurst", 32'(CPU_RST),  32'd1);

        // Reset in the middle of BYTES, then a clean one-word load
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("mid_busy", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_cs",      32'(CS),      32'd0);
        chk("mid_rst_bus",     Mem_Bus,      32'hFFFF_FFFF);
        chk("mid_rst_busy",    32'(BUSY),    32'd0);
        chk("mid_rst_cpu_rst", 32'(CPU_RST), 32'd1);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        wait_end(50);
        chk("post_rst_done", 32'(DONE), 32'd1);
        chk("post_rst_ram0", ram[0],    32'h1122_3344);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
